seq_alu: RTL

- Multi-cycle ALU stage directly upstream of the accumulator.
- Takes the accumulator value and a register-file operand, then computes add, sub, logic, iterative shift or iterative multiply.
- Presents a registered result on the accumulator's ALU data input.
- Its one-cycle `done` pulse is the accumulator write strobe when the ALU source is selected.

---
 rtl/seq_alu.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: single-cycle add/sub/logic,
// bit-serial shifts and a shift-add multiplier, with a one-cycle done strobe.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int unsigned SW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_MULH = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Iteration state layout: {last bit out, product high half, product low half / shift reg}
  function automatic logic [SW-1:0] f_step(input logic [2:0] f_op,
                                           input logic [WIDTH-1:0] m,
                                           input logic [SW-1:0] s);
    logic [WIDTH:0] sum;
    sum = {1'b0, s[2*WIDTH-1:WIDTH]} + (s[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    case (f_op)
      OP_SHL:  f_step = {s[WIDTH-1], {WIDTH{1'b0}}, s[WIDTH-2:0], 1'b0};
      OP_SHR:  f_step = {s[0], {WIDTH{1'b0}}, 1'b0, s[WIDTH-1:1]};
      default: f_step = {1'b0, sum, s[WIDTH-1:1]};
    endcase
  endfunction

  // Final {carry, result} from a completed iteration state.
  function automatic logic [WIDTH:0] f_fin(input logic [2:0] f_op,
                                           input logic [SW-1:0] s);
    case (f_op)
      OP_MUL:  f_fin = {|s[2*WIDTH-1:WIDTH], s[WIDTH-1:0]};
      OP_MULH: f_fin = {1'b0, s[2*WIDTH-1:WIDTH]};
      default: f_fin = {s[2*WIDTH], s[WIDTH-1:0]};
    endcase
  endfunction

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_m;
  logic [SW-1:0]    r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;

  logic [SW-1:0]    w_init;
  logic [SW-1:0]    w_first;
  logic [SW-1:0]    w_step;
  logic [WIDTH:0]   w_last;
  logic [WIDTH:0]   w_fast;
  logic [CW-1:0]    w_lat_m1;
  logic [2:0]       w_amt;

  // The first iteration happens on the accept edge, so L edges cover L steps.
  assign w_amt   = b[2:0];
  assign w_init  = {1'b0, {WIDTH{1'b0}}, (op[1] ? b : a)};
  assign w_first = f_step(op, a, w_init);
  assign w_step  = f_step(r_op, r_m, r_s);
  assign w_last  = f_fin(r_op, w_step);

  // Result for ops finishing on the accept edge, and remaining run length.
  always_comb begin
    w_fast   = '0;
    w_lat_m1 = '0;
    case (op)
      OP_ADD: w_fast = {1'b0, a} + {1'b0, b};
      OP_SUB: w_fast = {1'b0, a} - {1'b0, b};
      OP_AND: w_fast = {1'b0, a & b};
      OP_XOR: w_fast = {1'b0, a ^ b};
      OP_SHL, OP_SHR: begin
        if (w_amt == 3'd0) begin
          w_fast = {1'b0, a};
        end else begin
          w_fast   = f_fin(op, w_first);
          w_lat_m1 = CW'(w_amt - 3'd1);
        end
      end
      default: w_lat_m1 = CW'(WIDTH - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_m      <= '0;
      r_s      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_op   <= op;
            r_m    <= a;
            r_s    <= w_first;
            r_cnt  <= w_lat_m1;
            if (w_lat_m1 == '0) begin
              r_carry  <= w_fast[WIDTH];
              r_result <= w_fast[WIDTH-1:0];
              r_zero   <= (w_fast[WIDTH-1:0] == '0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == CW'(1)) begin
            r_carry  <= w_last[WIDTH];
            r_result <= w_last[WIDTH-1:0];
            r_zero   <= (w_last[WIDTH-1:0] == '0);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_s   <= w_step;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;

endmodule
